dcache_miss_ctrl: RTL and testbench

Sequencing controller for the memory-stage data cache. It detects load/store misses and, when the victim line is dirty, writes that line back to memory. It then fetches the missing line through the block-level memory port and drives the cache's block-write strobe to install it. It stalls the pipeline for the whole sequence and keeps saturating miss and writeback counters for performance logging.

---
 rtl/dcache_miss_ctrl_if.sv | 50 +++++
 rtl/dcache_miss_ctrl.sv | 122 ++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_miss_ctrl_if.sv
// dcache_miss_ctrl_if
// Groups every non-clock signal of the data-cache miss controller into one
// bundle. The controller uses the "master" modport. The pipeline, dcache and
// memory port use the "slave" modport.
//   i_mem_access / i_dcache_hit / i_dcache_dirty : pipeline and cache lookup status
//   i_addr / i_addr_wb / i_victim_block          : access address and victim line
//   o_wb_* / i_wb_done                           : writeback request to memory
//   o_rd_* / i_rd_done / i_rd_data               : refill request from memory
//   o_block_we / o_data_block                    : line install into the dcache
//   o_stall                                      : pipeline hold
//   o_miss_count / o_wb_count                    : saturating performance counters
interface dcache_miss_ctrl_if #(
   parameter int ADDR_WIDTH  = 64,
   parameter int BLOCK_WIDTH = 512,
   parameter int CNT_WIDTH   = 32
);
   logic                   i_mem_access;
   logic                   i_dcache_hit;
   logic                   i_dcache_dirty;
   logic [ADDR_WIDTH-1:0]  i_addr;
   logic [ADDR_WIDTH-1:0]  i_addr_wb;
   logic [BLOCK_WIDTH-1:0] i_victim_block;
   logic                   o_wb_valid;
   logic [ADDR_WIDTH-1:0]  o_wb_addr;
   logic [BLOCK_WIDTH-1:0] o_wb_data;
   logic                   i_wb_done;
   logic                   o_rd_valid;
   logic [ADDR_WIDTH-1:0]  o_rd_addr;
   logic                   i_rd_done;
   logic [BLOCK_WIDTH-1:0] i_rd_data;
   logic                   o_block_we;
   logic [BLOCK_WIDTH-1:0] o_data_block;
   logic                   o_stall;
   logic [CNT_WIDTH-1:0]   o_miss_count;
   logic [CNT_WIDTH-1:0]   o_wb_count;

   modport master (
      input  i_mem_access, i_dcache_hit, i_dcache_dirty, i_addr, i_addr_wb,
             i_victim_block, i_wb_done, i_rd_done, i_rd_data,
      output o_wb_valid, o_wb_addr, o_wb_data, o_rd_valid, o_rd_addr,
             o_block_we, o_data_block, o_stall, o_miss_count, o_wb_count
   );

   modport slave (
      output i_mem_access, i_dcache_hit, i_dcache_dirty, i_addr, i_addr_wb,
             i_victim_block, i_wb_done, i_rd_done, i_rd_data,
      input  o_wb_valid, o_wb_addr, o_wb_data, o_rd_valid, o_rd_addr,
             o_block_we, o_data_block, o_stall, o_miss_count, o_wb_count
   );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl
// Miss sequencer for the memory-stage data cache. On a load/store miss it
// optionally writes back the dirty victim line. It then refills the missing
// line and pulses the cache block-write strobe for one cycle to install it.
// The pipeline is stalled throughout.
// Ports:
//   i_clk  : clock, rising edge
//   i_arst : asynchronous active-low reset
//   bus    : dcache_miss_ctrl_if.master (cache status, memory requests,
//            install strobe, stall, performance counters)
module dcache_miss_ctrl #(
   parameter int ADDR_WIDTH  = 64,
   parameter int BLOCK_WIDTH = 512,
   parameter int CNT_WIDTH   = 32
) (
   input  logic              i_clk,
   input  logic              i_arst,
   dcache_miss_ctrl_if.master bus
);

   localparam int OFFS = $clog2(BLOCK_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = {{(ADDR_WIDTH-OFFS){1'b0}}, {OFFS{1'b1}}};
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, INSTALL} state_e;

   state_e                 state_q, state_d;
   logic                   wb_valid_q, wb_valid_d;
   logic                   rd_valid_q, rd_valid_d;
   logic                   block_we_q, block_we_d;
   logic [ADDR_WIDTH-1:0]  miss_addr_q, miss_addr_d;
   logic [ADDR_WIDTH-1:0]  wb_addr_q, wb_addr_d;
   logic [BLOCK_WIDTH-1:0] wb_data_q, wb_data_d;
   logic [BLOCK_WIDTH-1:0] fill_data_q, fill_data_d;
   logic [CNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;
   logic [CNT_WIDTH-1:0]   wb_cnt_q, wb_cnt_d;
   logic                   miss;

   assign miss = bus.i_mem_access & ~bus.i_dcache_hit;

   // Next-state logic. Each done pulse is only honoured in the state that owns
   // it, so stray or simultaneous pulses are naturally ignored.
   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
      fill_data_d = fill_data_q;
      miss_cnt_d  = miss_cnt_q;
      wb_cnt_d    = wb_cnt_q;
      case (state_q)
         IDLE: begin
            if (miss) begin
               miss_addr_d = bus.i_addr & ~OFFS_MASK;
               wb_addr_d   = bus.i_addr_wb;
               wb_data_d   = bus.i_victim_block;
               if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
               state_d = bus.i_dcache_dirty ? WRITEBACK : REFILL;
            end
         end
         WRITEBACK: begin
            if (bus.i_wb_done) begin
               if (wb_cnt_q != CNT_MAX) wb_cnt_d = wb_cnt_q + CNT_WIDTH'(1);
               state_d = REFILL;
            end
         end
         REFILL: begin
            if (bus.i_rd_done) begin
               fill_data_d = bus.i_rd_data;
               state_d     = INSTALL;
            end
         end
         INSTALL: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Request strobes are decoded from the next state so they leave a flop
      // in the same cycle the state register enters the matching state.
      wb_valid_d = (state_d == WRITEBACK);
      rd_valid_d = (state_d == REFILL);
      block_we_d = (state_d == INSTALL);
   end

   // All controller state. Reset aborts any transfer at once and drops requests.
   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
         state_q     <= IDLE;
         wb_valid_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         block_we_q  <= 1'b0;
         miss_addr_q <= '0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         fill_data_q <= '0;
         miss_cnt_q  <= '0;
         wb_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         wb_valid_q  <= wb_valid_d;
         rd_valid_q  <= rd_valid_d;
         block_we_q  <= block_we_d;
         miss_addr_q <= miss_addr_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         fill_data_q <= fill_data_d;
         miss_cnt_q  <= miss_cnt_d;
         wb_cnt_q    <= wb_cnt_d;
      end
   end

   // Stall is combinational in IDLE so the missing instruction never advances.
   assign bus.o_stall      = (state_q != IDLE) | miss;
   assign bus.o_wb_valid   = wb_valid_q;
   assign bus.o_wb_addr    = wb_addr_q;
   assign bus.o_wb_data    = wb_data_q;
   assign bus.o_rd_valid   = rd_valid_q;
   assign bus.o_rd_addr    = miss_addr_q;
   assign bus.o_block_we   = block_we_q;
   assign bus.o_data_block = fill_data_q;
   assign bus.o_miss_count = miss_cnt_q;
   assign bus.o_wb_count   = wb_cnt_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl
// Self-checking bench for dcache_miss_ctrl. A transaction-level model
// (pending writeback / pending refill / install due) predicts every output on
// each falling edge. Directed sequences pin the model with literal values.
// The counters are built 4 bits wide so that saturation is reachable.
module tb_dcache_miss_ctrl;

   localparam int AW      = 64;
   localparam int BW      = 512;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   dcache_miss_ctrl_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .CNT_WIDTH(CW)) bus ();

   dcache_miss_ctrl #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .CNT_WIDTH(CW)) dut (
      .i_clk  (clk),
      .i_arst (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: a miss accepted while nothing is outstanding queues an
   // optional writeback, a refill and then a one-cycle install.
   bit              m_pending_wb = 1'b0;
   bit              m_pending_rd = 1'b0;
   bit              m_install    = 1'b0;
   int unsigned     m_miss_cnt   = 0;
   int unsigned     m_wb_cnt     = 0;
   logic [AW-1:0]   m_miss_addr  = '0;
   logic [AW-1:0]   m_wb_addr    = '0;
   logic [BW-1:0]   m_wb_data    = '0;
   logic [BW-1:0]   m_fill       = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pending_wb <= 1'b0;
         m_pending_rd <= 1'b0;
         m_install    <= 1'b0;
         m_miss_cnt   <= 0;
         m_wb_cnt     <= 0;
         m_miss_addr  <= '0;
         m_wb_addr    <= '0;
         m_wb_data    <= '0;
         m_fill       <= '0;
      end else if (!(m_pending_wb || m_pending_rd || m_install)) begin
         if (bus.i_mem_access && !bus.i_dcache_hit) begin
            m_miss_addr  <= (bus.i_addr / 64) * 64;
            m_wb_addr    <= bus.i_addr_wb;
            m_wb_data    <= bus.i_victim_block;
            m_miss_cnt   <= (m_miss_cnt < CNT_MAX) ? m_miss_cnt + 1 : m_miss_cnt;
            m_pending_wb <= bus.i_dcache_dirty;
            m_pending_rd <= 1'b1;
         end
      end else if (m_pending_wb) begin
         if (bus.i_wb_done) begin
            m_pending_wb <= 1'b0;
            m_wb_cnt     <= (m_wb_cnt < CNT_MAX) ? m_wb_cnt + 1 : m_wb_cnt;
         end
      end else if (m_pending_rd) begin
         if (bus.i_rd_done) begin
            m_pending_rd <= 1'b0;
            m_fill       <= bus.i_rd_data;
            m_install    <= 1'b1;
         end
      end else begin
         m_install <= 1'b0;
      end
   end

   task automatic check_output(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      check_output("m_wb_valid", bus.o_wb_valid, m_pending_wb);
      check_output("m_rd_valid", bus.o_rd_valid, m_pending_rd && !m_pending_wb);
      check_output("m_block_we", bus.o_block_we, m_install);
      check_output("m_stall", bus.o_stall, m_pending_wb || m_pending_rd || m_install ||
                   (bus.i_mem_access && !bus.i_dcache_hit));
      check_output("m_wb_addr", bus.o_wb_addr, m_wb_addr);
      check_output("m_wb_data", bus.o_wb_data, m_wb_data);
      check_output("m_rd_addr", bus.o_rd_addr, m_miss_addr);
      check_output("m_data_block", bus.o_data_block, m_fill);
      check_output("m_miss_count", bus.o_miss_count, m_miss_cnt);
      check_output("m_wb_count", bus.o_wb_count, m_wb_cnt);
   end

   function automatic logic [BW-1:0] rand_block();
      logic [BW-1:0] r;
      for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input bit mem, input bit hit, input bit dirty,
                                 input bit wb_done, input bit rd_done);
      bus.i_mem_access   = mem;
      bus.i_dcache_hit   = hit;
      bus.i_dcache_dirty = dirty;
      bus.i_wb_done      = wb_done;
      bus.i_rd_done      = rd_done;
   endtask

   // One complete miss with the fastest possible memory response.
   task automatic do_miss(input bit dirty);
      step(); apply_stimulus(1, 0, dirty, 0, 0);
      bus.i_addr = {$urandom, $urandom}; bus.i_addr_wb = {$urandom, $urandom};
      bus.i_victim_block = rand_block();
      if (dirty) begin
         step(); apply_stimulus(1, 0, 0, 1, 0);
      end
      step(); apply_stimulus(1, 0, 0, 0, 1); bus.i_rd_data = rand_block();
      step(); apply_stimulus(1, 0, 0, 0, 0);
      step(); apply_stimulus(1, 1, 0, 0, 0);
      step(); apply_stimulus(0, 0, 0, 0, 0);
   endtask

   logic [BW-1:0] pat_a5;
   logic [BW-1:0] pat_vict;

   initial begin
      pat_a5   = {64{8'hA5}};
      pat_vict = {32{16'h1234}};
      apply_stimulus(0, 0, 0, 0, 0);
      bus.i_addr = '0; bus.i_addr_wb = '0; bus.i_victim_block = '0; bus.i_rd_data = '0;
      #2 rst_n = 1'b0;

      // Reset state, including the combinational stall during reset.
      @(negedge clk);
      check_output("rst_wb_valid", bus.o_wb_valid, 0);
      check_output("rst_rd_valid", bus.o_rd_valid, 0);
      check_output("rst_block_we", bus.o_block_we, 0);
      check_output("rst_stall_idle", bus.o_stall, 0);
      check_output("rst_miss_count", bus.o_miss_count, 0);
      bus.i_mem_access = 1'b1;
      #1 check_output("rst_stall_miss", bus.o_stall, 1);
      bus.i_mem_access = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;

      // Clean miss, refill done in cycle 4.
      step(); apply_stimulus(1, 0, 0, 0, 0); bus.i_addr = 64'h8000_1234;
      @(negedge clk); check_output("clean_c0_stall", bus.o_stall, 1);
      check_output("clean_c0_rd_valid", bus.o_rd_valid, 0);
      step(); @(negedge clk);
      check_output("clean_c1_rd_valid", bus.o_rd_valid, 1);
      check_output("clean_c1_rd_addr", bus.o_rd_addr, 64'h8000_1200);
      step(); step();
      step(); apply_stimulus(1, 0, 0, 0, 1); bus.i_rd_data = pat_a5;
      @(negedge clk); check_output("clean_c4_block_we", bus.o_block_we, 0);
      step(); apply_stimulus(1, 0, 0, 0, 0); bus.i_rd_data = '0;
      @(negedge clk); check_output("clean_c5_block_we", bus.o_block_we, 1);
      check_output("clean_c5_data_block", bus.o_data_block, pat_a5);
      step(); apply_stimulus(1, 1, 0, 0, 0);
      @(negedge clk); check_output("clean_c6_block_we", bus.o_block_we, 0);
      check_output("clean_c6_stall", bus.o_stall, 0);
      check_output("clean_miss_count", bus.o_miss_count, 1);
      check_output("clean_wb_count", bus.o_wb_count, 0);

      // Hits and non-memory traffic.
      for (int i = 0; i < 20; i++) begin
         step(); apply_stimulus(1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0, 0);
         bus.i_addr = {$urandom, $urandom};
         @(negedge clk); check_output("hit_stall", bus.o_stall, 0);
      end
      check_output("hit_miss_count", bus.o_miss_count, 1);

      // Dirty miss with stray done pulses in WRITEBACK and REFILL.
      step(); apply_stimulus(1, 0, 1, 0, 0);
      bus.i_addr = 64'h1000_0077; bus.i_addr_wb = 64'h4000; bus.i_victim_block = pat_vict;
      @(negedge clk); check_output("dirty_c0_wb_valid", bus.o_wb_valid, 0);
      step(); apply_stimulus(1, 0, 0, 0, 0);
      bus.i_addr_wb = 64'hDEAD; bus.i_victim_block = rand_block();
      @(negedge clk); check_output("dirty_c1_wb_valid", bus.o_wb_valid, 1);
      check_output("dirty_c1_wb_addr", bus.o_wb_addr, 64'h4000);
      check_output("dirty_c1_wb_data", bus.o_wb_data, pat_vict);
      step(); apply_stimulus(1, 0, 0, 0, 1);
      @(negedge clk); check_output("dirty_c2_rd_valid", bus.o_rd_valid, 0);
      step(); apply_stimulus(1, 0, 0, 1, 0);
      @(negedge clk); check_output("dirty_c3_wb_valid", bus.o_wb_valid, 1);
      check_output("dirty_c3_wb_data", bus.o_wb_data, pat_vict);
      check_output("dirty_c3_wb_count", bus.o_wb_count, 0);
      step(); apply_stimulus(1, 0, 0, 1, 0);
      @(negedge clk); check_output("dirty_c4_wb_valid", bus.o_wb_valid, 0);
      check_output("dirty_c4_rd_valid", bus.o_rd_valid, 1);
      check_output("dirty_c4_rd_addr", bus.o_rd_addr, 64'h1000_0040);
      check_output("dirty_c4_wb_count", bus.o_wb_count, 1);
      step(); apply_stimulus(1, 0, 0, 0, 0);
      @(negedge clk); check_output("dirty_c5_rd_valid", bus.o_rd_valid, 1);
      check_output("dirty_c5_wb_count", bus.o_wb_count, 1);
      check_output("dirty_miss_count", bus.o_miss_count, 2);
      step(); apply_stimulus(1, 0, 0, 0, 1); bus.i_rd_data = rand_block();
      step(); apply_stimulus(1, 0, 0, 0, 0);
      @(negedge clk); check_output("dirty_c7_block_we", bus.o_block_we, 1);
      step(); apply_stimulus(1, 1, 0, 0, 0);
      step(); apply_stimulus(0, 0, 0, 0, 0);

      // Reset in the second REFILL cycle, then a normal miss.
      step(); apply_stimulus(1, 0, 0, 0, 0); bus.i_addr = 64'h2222_3333_4444_5555;
      step();
      step(); #1 rst_n = 1'b0;
      #1 check_output("rstmid_rd_valid", bus.o_rd_valid, 0);
      check_output("rstmid_miss_count", bus.o_miss_count, 0);
      check_output("rstmid_wb_count", bus.o_wb_count, 0);
      bus.i_mem_access = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      step(); apply_stimulus(1, 0, 0, 0, 0); bus.i_addr = 64'h0000_0000_0000_0FC1;
      step(); @(negedge clk);
      check_output("rstmid_new_rd_valid", bus.o_rd_valid, 1);
      check_output("rstmid_new_rd_addr", bus.o_rd_addr, 64'h0FC0);
      check_output("rstmid_new_miss_count", bus.o_miss_count, 1);
      step(); apply_stimulus(1, 0, 0, 0, 1);
      step(); apply_stimulus(1, 0, 0, 0, 0);
      step(); apply_stimulus(1, 1, 0, 0, 0);
      step(); apply_stimulus(0, 0, 0, 0, 0);

      // Saturation: bring both counters to all-ones minus one, then 3 more misses.
      step(); rst_n = 1'b0; #2 rst_n = 1'b1;
      for (int i = 0; i < CNT_MAX - 1; i++) do_miss(1);
      @(negedge clk);
      check_output("sat_pre_miss", bus.o_miss_count, CNT_MAX - 1);
      check_output("sat_pre_wb", bus.o_wb_count, CNT_MAX - 1);
      for (int i = 0; i < 3; i++) do_miss(1);
      @(negedge clk);
      check_output("sat_miss", bus.o_miss_count, CNT_MAX);
      check_output("sat_wb", bus.o_wb_count, CNT_MAX);

      // Randomized traffic against the model, with occasional resets.
      step(); rst_n = 1'b0; #2 rst_n = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         step();
         apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                        1'($urandom_range(0, 2) == 0));
         bus.i_addr = {$urandom, $urandom};
         bus.i_addr_wb = {$urandom, $urandom};
         bus.i_victim_block = rand_block();
         bus.i_rd_data = rand_block();
         if ($urandom_range(0, 249) == 0) begin
            #1 rst_n = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1;
         end
      end

      step(); apply_stimulus(0, 0, 0, 0, 0);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
